// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store unit (RVX_Info).
// Holds the datapath width, the RISC-V funct3 access-size codes, the LSU
// state encoding and a helper that flags misaligned half/word accesses.
package rv_lsu_pkg;

  localparam int RVX_BUS_W = 32;

  // funct3 codes for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // access size, funct3[1:0]; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane steering for the load/store unit, purely combinational.
// Ports:
//   addr_lo_i  low two address bits of the access
//   funct3_i   access size (bits 1:0) and unsigned-load flag (bit 2)
//   st_data_i  store data (rs2)
//   ld_raw_i   raw word returned by the bus
//   be_o       byte enables for the bus
//   st_data_o  store data replicated across the lanes
//   ld_data_o  selected load lane, sign- or zero-extended
// Low address bits that are below the access size are ignored, so a
// misaligned half/word is steered as if it were aligned down.
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_unsigned;

  assign ld_unsigned = funct3_i[2];

  always_comb begin
    ld_byte = ld_raw_i[7:0];
    case (addr_lo_i)
      2'd0:    ld_byte = ld_raw_i[7:0];
      2'd1:    ld_byte = ld_raw_i[15:8];
      2'd2:    ld_byte = ld_raw_i[23:16];
      default: ld_byte = ld_raw_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
  end

  always_comb begin
    be_o      = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = ld_raw_i;
    case (funct3_i[1:0])
      SZ_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        ld_data_o = ld_raw_i;
      end
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one EX-stage result at a time, passes non-memory
// results straight to writeback, and runs loads/stores over a simple
// req/ack bus.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_*                EX-stage result and handshake (ex_ready out)
//   bus_*               memory bus request (held until bus_ack), rdata in
//   wb_valid/rd/data    one-cycle writeback pulse
//   misalign_err        one-cycle pulse for a rejected misaligned access
// Build option: RVX_LSU_MISALIGN_TRAP_EN rejects misaligned half/word
// accesses with misalign_err; without it misalign_err is tied low and the
// offending low address bits are ignored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a new EX result; non-memory ops retire from here
// BUS     | bus_req held with stable address/data until bus_ack
// RESP    | load data is on wb_data with wb_valid for one cycle
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int BUS_W = RVX_BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [BUS_W-1:0] ex_addr,
  input  logic [BUS_W-1:0] ex_wdata,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [4:0]       ex_rd,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  output logic [3:0]       bus_be,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [BUS_W-1:0] wb_data,
  output logic             misalign_err
);

  lsu_state_e       state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             load_q, load_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [BUS_W-1:0] wb_data_q, wb_data_d;
`ifdef RVX_LSU_MISALIGN_TRAP_EN
  logic             misalign_q, misalign_d;
`endif

  logic             accept;
  logic             is_mem;
  logic [3:0]       be_w;
  logic [31:0]      st_data_w;
  logic [31:0]      ld_data_w;

  rv_lsu_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .st_data_i (wdata_q),
    .ld_raw_i  (bus_rdata),
    .be_o      (be_w),
    .st_data_o (st_data_w),
    .ld_data_o (ld_data_w)
  );

  assign ex_ready = (state_q == ST_IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = ex_is_load | ex_is_store;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    load_d     = load_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef RVX_LSU_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_addr;
            wb_rd_d    = ex_rd;
          end
`ifdef RVX_LSU_MISALIGN_TRAP_EN
          else if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
            misalign_d = 1'b1;
          end
`endif
          else begin
            addr_d   = ex_addr;
            wdata_d  = ex_wdata;
            funct3_d = ex_funct3;
            // load wins when both flags are set
            load_d   = ex_is_load;
            rd_d     = ex_rd;
            state_d  = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          if (load_q) begin
            // lane extraction happens here so RESP only has to present it
            wb_valid_d = 1'b1;
            wb_data_d  = ld_data_w;
            wb_rd_d    = rd_q;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'b000;
      load_q     <= 1'b0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
`ifdef RVX_LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
`ifdef RVX_LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Bus outputs derive from registers captured at accept, so they stay
  // stable for the whole BUS state and read as zero everywhere else.
  assign bus_req   = (state_q == ST_BUS);
  assign bus_we    = bus_req & ~load_q;
  assign bus_addr  = bus_req ? {addr_q[BUS_W-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be_w : 4'b0000;
  assign bus_wdata = bus_req ? st_data_w : '0;

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

`ifdef RVX_LSU_MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
